// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolution slice.
// Holds the BranchOp encoding, the resolve FSM state type and the
// J/JAL target helper.
package branch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned JIDX_W   = 26;
  localparam int unsigned SHADOW_W = 2;

  // BranchOp encoding; codes 10..15 are reserved and behave as NONE
  typedef enum logic [OP_W-1:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BGEZ = 4'd3,
    BR_BGTZ = 4'd4,
    BR_BLEZ = 4'd5,
    BR_BLTZ = 4'd6,
    BR_J    = 4'd7,
    BR_JAL  = 4'd8,
    BR_JR   = 4'd9
  } branch_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SHADOW   = 2'd2
  } brs_state_e;

  // Pseudo-direct jump target: top nibble of PC+4, index, word alignment
  function automatic logic [XLEN-1:0] jump_target(input logic [3:0]        pc_hi,
                                                  input logic [JIDX_W-1:0] idx);
    return {pc_hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolve_stage_if.sv
// Bus between ID/EX and the branch resolve stage, plus the redirect
// outputs towards fetch/decode.
//   master : producer side (drives operands, observes redirect/link/count)
//   slave  : the resolve stage itself
interface branch_resolve_stage_if #(
  parameter int unsigned CNT_W = 16
);
  import branch_pkg::*;

  logic                  Stall;
  logic                  InValid;
  logic [OP_W-1:0]       BranchOp;
  logic [XLEN-1:0]       PCPlus4;
  logic [XLEN-1:0]       ShiftResult;
  logic [JIDX_W-1:0]     JumpIndex;
  logic [XLEN-1:0]       RegA;
  logic [XLEN-1:0]       RegB;

  logic                  Redirect;
  logic [XLEN-1:0]       TargetPC;
  logic                  Flush;
  logic                  LinkValid;
  logic [XLEN-1:0]       LinkAddr;
  logic [CNT_W-1:0]      TakenCount;

  modport master (
    output Stall, InValid, BranchOp, PCPlus4, ShiftResult, JumpIndex, RegA, RegB,
    input  Redirect, TargetPC, Flush, LinkValid, LinkAddr, TakenCount
  );

  modport slave (
    input  Stall, InValid, BranchOp, PCPlus4, ShiftResult, JumpIndex, RegA, RegB,
    output Redirect, TargetPC, Flush, LinkValid, LinkAddr, TakenCount
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
//   BranchOp : decoded branch opcode
//   RegA/RegB: forwarded rs/rt values, compared as signed
//   taken_c  : the op redirects the PC
//   link_c   : the op writes a return address (JAL)
module branch_cond_eval
  import branch_pkg::*;
(
  input  branch_op_e      BranchOp,
  input  logic [XLEN-1:0] RegA,
  input  logic [XLEN-1:0] RegB,
  output logic            taken_c,
  output logic            link_c
);

  logic a_neg;
  logic a_zero;

  assign a_neg  = RegA[XLEN-1];
  assign a_zero = (RegA == '0);

  always_comb begin
    taken_c = 1'b0;
    link_c  = 1'b0;
    unique case (BranchOp)
      BR_BEQ:  taken_c = (RegA == RegB);
      BR_BNE:  taken_c = (RegA != RegB);
      BR_BGEZ: taken_c = !a_neg;
      BR_BGTZ: taken_c = !a_neg && !a_zero;
      BR_BLEZ: taken_c = a_neg || a_zero;
      BR_BLTZ: taken_c = a_neg;
      BR_J:    taken_c = 1'b1;
      BR_JAL: begin
        taken_c = 1'b1;
        link_c  = 1'b1;
      end
      BR_JR:   taken_c = 1'b1;
      default: begin
        taken_c = 1'b0;
        link_c  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolve_stage.sv
// EX-stage branch/jump resolution.
// Computes the branch target, evaluates the condition, and issues a
// registered one-cycle Redirect/Flush (plus LinkValid for JAL). After a
// redirect the stage ignores SHADOW_CYCLES unstalled cycles of wrong-path
// input, and keeps a saturating count of taken branches.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : slave side of branch_resolve_stage_if (operands in,
//                Redirect/TargetPC/Flush/LinkValid/LinkAddr/TakenCount out)
module branch_resolve_stage
  import branch_pkg::*;
#(
  parameter int unsigned SHADOW_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  branch_resolve_stage_if.slave bus
);

  brs_state_e            state_q;
  logic [SHADOW_W-1:0]   shadow_q;
  logic                  redirect_q;
  logic                  flush_q;
  logic                  link_valid_q;
  logic [XLEN-1:0]       target_q;
  logic [XLEN-1:0]       link_addr_q;
  logic [CNT_W-1:0]      taken_count_q;

  branch_op_e            op;
  logic                  taken_c;
  logic                  link_c;
  logic                  accept_c;
  logic [XLEN-1:0]       target_d;

  assign op = branch_op_e'(bus.BranchOp);

  branch_cond_eval u_cond (
    .BranchOp (op),
    .RegA     (bus.RegA),
    .RegB     (bus.RegB),
    .taken_c  (taken_c),
    .link_c   (link_c)
  );

  // Target mux; conditional branches share the PC-relative adder
  always_comb begin
    target_d = bus.PCPlus4 + bus.ShiftResult;
    unique case (op)
      BR_J, BR_JAL: target_d = jump_target(bus.PCPlus4[XLEN-1:XLEN-4], bus.JumpIndex);
      BR_JR:        target_d = bus.RegA;
      default:      target_d = bus.PCPlus4 + bus.ShiftResult;
    endcase
  end

  assign accept_c = bus.InValid && !bus.Stall && (state_q == ST_IDLE);

  // Resolve FSM; strobes default low so every pulse lasts one cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      shadow_q      <= '0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      link_valid_q  <= 1'b0;
      target_q      <= '0;
      link_addr_q   <= '0;
      taken_count_q <= '0;
    end else begin
      redirect_q   <= 1'b0;
      flush_q      <= 1'b0;
      link_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept_c && taken_c) begin
            state_q      <= ST_REDIRECT;
            redirect_q   <= 1'b1;
            flush_q      <= 1'b1;
            target_q     <= target_d;
            link_valid_q <= link_c;
            if (link_c) begin
              link_addr_q <= bus.PCPlus4;
            end
            if (taken_count_q != {CNT_W{1'b1}}) begin
              taken_count_q <= taken_count_q + CNT_W'(1);
            end
          end
        end
        // The pulse is already on the outputs; Stall does not extend it
        ST_REDIRECT: begin
          state_q  <= ST_SHADOW;
          shadow_q <= SHADOW_W'(SHADOW_CYCLES);
        end
        // Drop wrong-path instructions; only unstalled cycles count down
        ST_SHADOW: begin
          if (!bus.Stall) begin
            if (shadow_q <= SHADOW_W'(1)) begin
              state_q  <= ST_IDLE;
              shadow_q <= '0;
            end else begin
              shadow_q <= shadow_q - SHADOW_W'(1);
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          shadow_q <= '0;
        end
      endcase
    end
  end

  assign bus.Redirect   = redirect_q;
  assign bus.Flush      = flush_q;
  assign bus.TargetPC   = target_q;
  assign bus.LinkValid  = link_valid_q;
  assign bus.LinkAddr   = link_addr_q;
  assign bus.TakenCount = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Bench for branch_resolve_stage: two instances (SHADOW_CYCLES=1/CNT_W=16
// and SHADOW_CYCLES=2/CNT_W=3) share one stimulus stream and are compared
// every cycle against a behavioural model, with directed scenarios followed
// by random traffic.
module tb_branch_resolve_stage;

  logic        Clk = 1'b0;
  logic        rst;
  logic        in_valid, in_stall;
  logic [3:0]  in_op;
  logic [31:0] in_pc4, in_sh, in_a, in_b;
  logic [25:0] in_idx;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  branch_resolve_stage_if #(.CNT_W(16)) bus0 ();
  branch_resolve_stage_if #(.CNT_W(3))  bus1 ();

  assign bus0.Stall = in_stall;      assign bus1.Stall = in_stall;
  assign bus0.InValid = in_valid;    assign bus1.InValid = in_valid;
  assign bus0.BranchOp = in_op;      assign bus1.BranchOp = in_op;
  assign bus0.PCPlus4 = in_pc4;      assign bus1.PCPlus4 = in_pc4;
  assign bus0.ShiftResult = in_sh;   assign bus1.ShiftResult = in_sh;
  assign bus0.JumpIndex = in_idx;    assign bus1.JumpIndex = in_idx;
  assign bus0.RegA = in_a;           assign bus1.RegA = in_a;
  assign bus0.RegB = in_b;           assign bus1.RegB = in_b;

  branch_resolve_stage #(.SHADOW_CYCLES(1), .CNT_W(16)) dut0 (
    .Clk(Clk), .Reset(rst), .bus(bus0.slave));
  branch_resolve_stage #(.SHADOW_CYCLES(2), .CNT_W(3)) dut1 (
    .Clk(Clk), .Reset(rst), .bus(bus1.slave));

  // Reference model: a pending pulse, a count of cycles still to ignore,
  // and an integer taken count clipped to the counter's maximum.
  int          m_sc[2]   = '{1, 2};
  int unsigned m_max[2]  = '{65535, 7};
  bit          m_pulse[2];
  bit          m_link[2];
  int          m_ignore[2];
  int unsigned m_count[2];
  logic [31:0] m_tgt[2];
  logic [31:0] m_laddr[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd1: return a == b;
      4'd2: return a != b;
      4'd3: return $signed(a) >= 0;
      4'd4: return $signed(a) > 0;
      4'd5: return $signed(a) <= 0;
      4'd6: return $signed(a) < 0;
      4'd7, 4'd8, 4'd9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [3:0] op);
    case (op)
      4'd7, 4'd8: return {in_pc4[31:28], in_idx, 2'b00};
      4'd9:       return in_a;
      default:    return in_pc4 + in_sh;
    endcase
  endfunction

  task automatic model_step(input int k);
    if (rst) begin
      m_pulse[k] = 0; m_link[k] = 0; m_ignore[k] = 0; m_count[k] = 0;
    end else if (m_pulse[k]) begin
      m_pulse[k] = 0; m_link[k] = 0; m_ignore[k] = m_sc[k];
    end else if (m_ignore[k] > 0) begin
      if (!in_stall) m_ignore[k]--;
    end else if (in_valid && !in_stall && ref_taken(in_op, in_a, in_b)) begin
      m_pulse[k] = 1;
      m_tgt[k]   = ref_target(in_op);
      m_link[k]  = (in_op == 4'd8);
      m_laddr[k] = in_pc4;
      if (m_count[k] < m_max[k]) m_count[k]++;
    end
  endtask

  task automatic compare(input int k, input logic red, input logic fl, input logic lv,
                         input logic [31:0] tgt, input logic [31:0] la, input logic [31:0] cnt);
    check_eq($sformatf("i%0d_redirect", k), 32'(red), 32'(m_pulse[k]));
    check_eq($sformatf("i%0d_flush", k), 32'(fl), 32'(m_pulse[k]));
    check_eq($sformatf("i%0d_linkvalid", k), 32'(lv), 32'(m_pulse[k] && m_link[k]));
    check_eq($sformatf("i%0d_count", k), cnt, m_count[k]);
    if (m_pulse[k]) check_eq($sformatf("i%0d_target", k), tgt, m_tgt[k]);
    if (m_pulse[k] && m_link[k]) check_eq($sformatf("i%0d_linkaddr", k), la, m_laddr[k]);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step(0);
    model_step(1);
    #1;
    compare(0, bus0.Redirect, bus0.Flush, bus0.LinkValid, bus0.TargetPC, bus0.LinkAddr,
            32'(bus0.TakenCount));
    compare(1, bus1.Redirect, bus1.Flush, bus1.LinkValid, bus1.TargetPC, bus1.LinkAddr,
            32'(bus1.TakenCount));
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc4, input logic [31:0] sh);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_pc4 = pc4; in_sh = sh;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [31:0] cnt_before;

  initial begin
    rst = 1'b1; in_valid = 0; in_stall = 0; in_op = 0;
    in_pc4 = 0; in_sh = 0; in_a = 0; in_b = 0; in_idx = 0;
    tick(); tick();
    check_eq("rst_redirect", 32'(bus0.Redirect), 32'd0);
    check_eq("rst_count", 32'(bus0.TakenCount), 32'd0);
    rst = 1'b0;
    idle(1);

    // BEQ taken with a negative offset
    present(4'd1, 32'd5, 32'd5, 32'h0040_0010, 32'hFFFF_FFF8);
    tick();
    check_eq("beq_redirect", 32'(bus0.Redirect), 32'd1);
    check_eq("beq_target", bus0.TargetPC, 32'h0040_0008);
    check_eq("beq_count", 32'(bus0.TakenCount), 32'd1);
    idle(3);

    // BLTZ on zero, then on a negative value
    present(4'd6, 32'h0, 32'h0, 32'h0000_0100, 32'h10);
    tick();
    check_eq("bltz0_redirect", 32'(bus0.Redirect), 32'd0);
    present(4'd6, 32'h8000_0000, 32'h0, 32'h0000_0100, 32'h10);
    tick();
    check_eq("bltz_target", bus0.TargetPC, 32'h0000_0110);
    idle(3);

    // JAL
    in_idx = 26'h0000100;
    present(4'd8, 32'h0, 32'h0, 32'h1000_0004, 32'h0);
    tick();
    check_eq("jal_target", bus0.TargetPC, 32'h1000_0400);
    check_eq("jal_linkvalid", 32'(bus0.LinkValid), 32'd1);
    check_eq("jal_linkaddr", bus0.LinkAddr, 32'h1000_0004);
    idle(3);

    // Taken BNE then taken BEQ right behind it: second is wrong-path
    cnt_before = 32'(bus0.TakenCount);
    present(4'd2, 32'd1, 32'd2, 32'h0000_2000, 32'h40);
    tick();
    present(4'd1, 32'd7, 32'd7, 32'h0000_2004, 32'h80);
    tick();
    check_eq("b2b_dropped", 32'(bus0.Redirect), 32'd0);
    tick();
    check_eq("b2b_shadow", 32'(bus0.Redirect), 32'd0);
    check_eq("b2b_count", 32'(bus0.TakenCount), cnt_before + 32'd1);
    tick();
    check_eq("after_shadow_redirect", 32'(bus0.Redirect), 32'd1);
    check_eq("after_shadow_target", bus0.TargetPC, 32'h0000_2084);
    idle(4);

    // Stall held during SHADOW, then a stalled JR in IDLE
    present(4'd7, 32'h0, 32'h0, 32'h0000_3000, 32'h0);
    tick();
    in_valid = 1'b0; in_stall = 1'b1;
    tick(); tick(); tick(); tick();
    present(4'd9, 32'hDEAD_BEEC, 32'h0, 32'h0000_4000, 32'h0);
    tick();
    check_eq("stall_jr_hold", 32'(bus0.Redirect), 32'd0);
    in_stall = 1'b0;
    tick(); tick(); tick();
    idle(3);

    // Reset during the redirect cycle aborts everything
    present(4'd3, 32'd4, 32'd0, 32'h0000_5000, 32'h20);
    tick();
    check_eq("pre_reset_redirect", 32'(bus0.Redirect), 32'd1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check_eq("mid_reset_redirect", 32'(bus0.Redirect), 32'd0);
    check_eq("mid_reset_target", bus0.TargetPC, 32'd0);
    check_eq("mid_reset_count", 32'(bus0.TakenCount), 32'd0);
    rst = 1'b0;
    idle(1);

    // Saturation on the 3-bit counter instance
    for (int i = 0; i < 9; i++) begin
      present(4'd4, 32'd9, 32'd0, 32'h0000_6000, 32'h4);
      tick();
      idle(3);
    end
    check_eq("sat_count_small", 32'(bus1.TakenCount), 32'd7);
    check_eq("sat_count_wide", 32'(bus0.TakenCount), 32'd9);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 9) < 8);
      in_stall = ($urandom_range(0, 4) == 0);
      in_op    = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: in_a = 32'd0;
        1: in_a = 32'($signed($urandom_range(0, 4)) - 2);
        2: in_a = 32'h8000_0000;
        default: in_a = $urandom;
      endcase
      in_b   = ($urandom_range(0, 1) == 0) ? in_a : $urandom;
      in_pc4 = $urandom & 32'hFFFF_FFFC;
      in_sh  = $urandom << 2;
      in_idx = 26'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
